// File: rtl/nfc_op_seq_pkg.sv
// Shared definitions for the NAND operation sequencer: op codes, NAND command bytes, FSM states.
package nfc_op_seq_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_PROG  = 2'b01,
        OP_ERASE = 2'b10,
        OP_RESET = 2'b11
    } op_t;

    localparam logic [7:0] CMD_READ1  = 8'h00;
    localparam logic [7:0] CMD_READ2  = 8'h30;
    localparam logic [7:0] CMD_PROG1  = 8'h80;
    localparam logic [7:0] CMD_PROG2  = 8'h10;
    localparam logic [7:0] CMD_ERASE1 = 8'h60;
    localparam logic [7:0] CMD_ERASE2 = 8'hD0;
    localparam logic [7:0] CMD_STATUS = 8'h70;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD1,
        ST_ADDR,
        ST_DATA,
        ST_CMD2,
        ST_WB,
        ST_RBW,
        ST_SCMD,
        ST_SRD,
        ST_DONE
    } state_t;

    // Opening command byte of each operation
    function automatic logic [7:0] first_cmd(input op_t op);
        case (op)
            OP_READ:  first_cmd = CMD_READ1;
            OP_PROG:  first_cmd = CMD_PROG1;
            OP_ERASE: first_cmd = CMD_ERASE1;
            default:  first_cmd = CMD_RESET;
        endcase
    endfunction

    // Confirm command byte that starts the array operation (RESET has none)
    function automatic logic [7:0] confirm_cmd(input op_t op);
        case (op)
            OP_READ:  confirm_cmd = CMD_READ2;
            OP_PROG:  confirm_cmd = CMD_PROG2;
            default:  confirm_cmd = CMD_ERASE2;
        endcase
    endfunction

endpackage

// File: rtl/nfc_op_seq_rb_wait.sv
// R/B# handling for the sequencer: 2-FF synchronizer, tWB delay counter and busy timeout counter.
module nfc_rb_wait #(
    parameter int TWB_CYC = 8,
    parameter int TO_W    = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_nf_rb,
    input  logic i_wb,
    input  logic i_rbw,
    output logic o_wb_done,
    output logic o_rb_ready,
    output logic o_rb_timeout
);

    localparam int WB_W = (TWB_CYC > 1) ? $clog2(TWB_CYC) : 1;

    logic            r_rb_meta;
    logic            r_rb_sync;
    logic [WB_W-1:0] r_wb_cnt;
    logic [TO_W-1:0] r_to_cnt;

    // Bring the asynchronous R/B# pin into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rb_meta <= 1'b0;
            r_rb_sync <= 1'b0;
        end else begin
            r_rb_meta <= i_nf_rb;
            r_rb_sync <= r_rb_meta;
        end
    end

    // tWB counter: runs only while the sequencer sits in WB, cleared otherwise
    always_ff @(posedge clk) begin
        if (rst || !i_wb) begin
            r_wb_cnt <= '0;
        end else if (!o_wb_done) begin
            r_wb_cnt <= r_wb_cnt + 1'b1;
        end
    end

    // Busy timeout counter: runs while waiting on R/B#, saturates at all-ones
    always_ff @(posedge clk) begin
        if (rst || !i_rbw) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign o_wb_done    = i_wb && (r_wb_cnt == WB_W'(TWB_CYC - 1));
    assign o_rb_ready   = i_rbw && r_rb_sync;
    assign o_rb_timeout = i_rbw && (r_to_cnt == '1);

endmodule

// File: rtl/nfc_op_seq.sv
// NAND operation sequencer: expands one op request into nfc_if CMD/ADDR/DATA steps, waits on R/B#
// and reads status back after program and erase.
module nfc_op_seq
    import nfc_op_seq_pkg::*;
#(
    parameter int SFR_WID = 8,
    parameter int TWB_CYC = 8,
    parameter int TO_W    = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_start,
    input  logic [1:0]         op_type,
    input  logic [31:0]        op_col_addr,
    input  logic [31:0]        op_row_addr,
    input  logic [5:0]         op_addr_cnt,
    input  logic [13:0]        op_dat_cnt,
    output logic               op_busy,
    output logic               op_done,
    output logic               op_err,
    output logic [7:0]         op_status,
    input  logic               nf_rb,
    output logic               nfc_cmd_en,
    output logic [SFR_WID-1:0] nfc_if_cmd,
    output logic               nfc_addr_en,
    output logic [31:0]        nfc_col_addr,
    output logic [31:0]        nfc_row_addr,
    output logic [5:0]         nfc_addr_cnt,
    output logic               nfc_dat_en,
    output logic               nfc_dat_dir,
    output logic [13:0]        nfc_dat_cnt,
    input  logic               nfif_cmd_done,
    input  logic               nfif_addr_done,
    input  logic               nfif_dat_done,
    input  logic               nfif_data_wr,
    input  logic [7:0]         nfif_data_out
);

    state_t      r_state;
    state_t      w_next;
    op_t         r_op;
    logic [31:0] r_col;
    logic [31:0] r_row;
    logic [5:0]  r_acnt;
    logic [13:0] r_dcnt;
    logic        r_issued;
    logic        r_hold;
    logic        r_err;
    logic [7:0]  r_status;

    logic        w_accept;
    logic        w_issue_state;
    logic        w_fire;
    logic        w_step_done;
    logic        w_wb_done;
    logic        w_rb_ready;
    logic        w_rb_timeout;

    nfc_rb_wait #(
        .TWB_CYC (TWB_CYC),
        .TO_W    (TO_W)
    ) u_rb_wait (
        .clk          (clk),
        .rst          (rst),
        .i_nf_rb      (nf_rb),
        .i_wb         (r_state == ST_WB),
        .i_rbw        (r_state == ST_RBW),
        .o_wb_done    (w_wb_done),
        .o_rb_ready   (w_rb_ready),
        .o_rb_timeout (w_rb_timeout)
    );

    assign w_accept      = (r_state == ST_IDLE) && op_start;
    assign w_issue_state = (r_state == ST_CMD1) || (r_state == ST_ADDR) || (r_state == ST_DATA) ||
                           (r_state == ST_CMD2) || (r_state == ST_SCMD) || (r_state == ST_SRD);
    // One enable per issuing state, held off for the cycle nfc_if spends in END after a done
    assign w_fire        = w_issue_state && !r_issued && !r_hold;

    // Select the done pulse this state waits for; anything else is ignored
    always_comb begin
        w_step_done = 1'b0;
        case (r_state)
            ST_CMD1, ST_CMD2, ST_SCMD: w_step_done = nfif_cmd_done;
            ST_ADDR:                   w_step_done = nfif_addr_done;
            ST_DATA, ST_SRD:           w_step_done = nfif_dat_done;
            default:                   w_step_done = 1'b0;
        endcase
        w_step_done = w_step_done && r_issued;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: step ordering per operation type
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (op_start)    w_next = ST_CMD1;
            ST_CMD1: if (w_step_done) w_next = (r_op == OP_RESET) ? ST_WB : ST_ADDR;
            ST_ADDR: if (w_step_done) w_next = (r_op == OP_PROG) ? ST_DATA : ST_CMD2;
            ST_DATA: if (w_step_done) w_next = (r_op == OP_PROG) ? ST_CMD2 : ST_DONE;
            ST_CMD2: if (w_step_done) w_next = ST_WB;
            ST_WB:   if (w_wb_done)   w_next = ST_RBW;
            ST_RBW: begin
                if (w_rb_ready) begin
                    case (r_op)
                        OP_READ:  w_next = ST_DATA;
                        OP_RESET: w_next = ST_DONE;
                        default:  w_next = ST_SCMD;
                    endcase
                end else if (w_rb_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_SCMD: if (w_step_done) w_next = ST_SRD;
            ST_SRD:  if (w_step_done) w_next = ST_DONE;
            ST_DONE:                  w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    // Output decode from state and step-issue flags
    always_comb begin
        nfc_cmd_en  = 1'b0;
        nfc_if_cmd  = '0;
        nfc_addr_en = 1'b0;
        nfc_dat_en  = 1'b0;
        nfc_dat_dir = 1'b0;
        nfc_dat_cnt = '0;
        op_done     = 1'b0;
        op_busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
        case (r_state)
            ST_CMD1: begin
                nfc_cmd_en = w_fire;
                nfc_if_cmd = SFR_WID'(first_cmd(r_op));
            end
            ST_ADDR: nfc_addr_en = w_fire;
            ST_DATA: begin
                nfc_dat_en  = w_fire;
                nfc_dat_dir = (r_op == OP_PROG);
                nfc_dat_cnt = r_dcnt;
            end
            ST_CMD2: begin
                nfc_cmd_en = w_fire;
                nfc_if_cmd = SFR_WID'(confirm_cmd(r_op));
            end
            ST_SCMD: begin
                nfc_cmd_en = w_fire;
                nfc_if_cmd = SFR_WID'(CMD_STATUS);
            end
            ST_SRD: begin
                nfc_dat_en  = w_fire;
                nfc_dat_cnt = 14'd1;
            end
            ST_DONE: op_done = 1'b1;
            default: ;
        endcase
    end

    // Step-issue bookkeeping: mark the enable as sent, insert the END gap after a done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_hold <= 1'b0;
            if (r_state != w_next) begin
                r_issued <= 1'b0;
                r_hold   <= w_step_done;
            end else if (w_fire) begin
                r_issued <= 1'b1;
            end
        end
    end

    // Request latch, status capture and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_READ;
            r_col    <= '0;
            r_row    <= '0;
            r_acnt   <= '0;
            r_dcnt   <= '0;
            r_err    <= 1'b0;
            r_status <= '0;
        end else if (w_accept) begin
            r_op   <= op_t'(op_type);
            r_col  <= op_col_addr;
            r_row  <= op_row_addr;
            r_acnt <= (op_t'(op_type) == OP_ERASE) ? {op_addr_cnt[5:3], 3'b000} : op_addr_cnt;
            r_dcnt <= op_dat_cnt;
            r_err  <= 1'b0;
        end else if ((r_state == ST_RBW) && w_rb_timeout && !w_rb_ready) begin
            r_err <= 1'b1;
        end else if ((r_state == ST_SRD) && r_issued && nfif_data_wr) begin
            r_status <= nfif_data_out;
            r_err    <= r_err | nfif_data_out[0];
        end
    end

    assign nfc_col_addr = r_col;
    assign nfc_row_addr = r_row;
    assign nfc_addr_cnt = r_acnt;
    assign op_err       = r_err;
    assign op_status    = r_status;

endmodule

// File: tb/tb_nfc_op_seq.sv
// Bench for nfc_op_seq: nfc_if responder, R/B# driver and a step-list reference model per operation.
module tb_nfc_op_seq;

  localparam int TWB_CYC = 8;
  localparam int TO_W    = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_start;
  logic [1:0]  op_type;
  logic [31:0] op_col_addr, op_row_addr;
  logic [5:0]  op_addr_cnt;
  logic [13:0] op_dat_cnt;
  logic        op_busy, op_done, op_err;
  logic [7:0]  op_status;
  logic        nf_rb;
  logic        nfc_cmd_en, nfc_addr_en, nfc_dat_en, nfc_dat_dir;
  logic [7:0]  nfc_if_cmd;
  logic [31:0] nfc_col_addr, nfc_row_addr;
  logic [5:0]  nfc_addr_cnt;
  logic [13:0] nfc_dat_cnt;
  logic        nfif_cmd_done, nfif_addr_done, nfif_dat_done, nfif_data_wr;
  logic [7:0]  nfif_data_out;
  logic [106:0] w_all;

  assign w_all = {op_busy, op_done, op_err, op_status, nfc_cmd_en, nfc_if_cmd, nfc_addr_en,
                  nfc_col_addr, nfc_row_addr, nfc_addr_cnt, nfc_dat_en, nfc_dat_dir, nfc_dat_cnt};

  nfc_op_seq #(.SFR_WID(8), .TWB_CYC(TWB_CYC), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .op_start(op_start), .op_type(op_type),
    .op_col_addr(op_col_addr), .op_row_addr(op_row_addr), .op_addr_cnt(op_addr_cnt),
    .op_dat_cnt(op_dat_cnt), .op_busy(op_busy), .op_done(op_done), .op_err(op_err),
    .op_status(op_status), .nf_rb(nf_rb), .nfc_cmd_en(nfc_cmd_en), .nfc_if_cmd(nfc_if_cmd),
    .nfc_addr_en(nfc_addr_en), .nfc_col_addr(nfc_col_addr), .nfc_row_addr(nfc_row_addr),
    .nfc_addr_cnt(nfc_addr_cnt), .nfc_dat_en(nfc_dat_en), .nfc_dat_dir(nfc_dat_dir),
    .nfc_dat_cnt(nfc_dat_cnt), .nfif_cmd_done(nfif_cmd_done), .nfif_addr_done(nfif_addr_done),
    .nfif_dat_done(nfif_dat_done), .nfif_data_wr(nfif_data_wr), .nfif_data_out(nfif_data_out)
  );

  typedef struct {
    int          kind;   // 0 cmd, 1 addr, 2 data
    logic [7:0]  cmd;
    logic        dir;
    logic [13:0] cnt;
    logic [5:0]  acnt;
    logic [31:0] col;
    logic [31:0] row;
    int          cyc;
    bit          arb;    // step follows the R/B# wait rather than a done pulse
  } ev_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  ev_t  evq[$];
  int   done_cyc[$];
  int   n_opdone = 0;
  int   opdone_cyc = 0;
  logic busy_at_done = 1'b0;
  int   n_multi_en = 0;
  int   conf_done_cyc = 0;
  int   rb_rise_cyc = 0;
  int   rb_busy = 0;
  bit   rb_release = 1'b0;
  logic [7:0] status_byte = 8'h00;
  logic [7:0] last_cmd = 8'h00;
  logic [7:0] model_status = 8'h00;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic ev_t mk(input int k, input logic [7:0] c, input logic d, input logic [13:0] n, input bit a);
    ev_t e;
    e.kind = k; e.cmd = c; e.dir = d; e.cnt = n; e.arb = a;
    e.acnt = '0; e.col = '0; e.row = '0; e.cyc = 0;
    return e;
  endfunction

  function automatic bit is_confirm(input logic [7:0] c);
    return (c == 8'h30) || (c == 8'h10) || (c == 8'hD0) || (c == 8'hFF);
  endfunction

  initial forever begin
    ev_t e;
    @(negedge clk);
    if (int'(nfc_cmd_en) + int'(nfc_addr_en) + int'(nfc_dat_en) > 1) n_multi_en++;
    if (nfc_cmd_en || nfc_addr_en || nfc_dat_en) begin
      e = mk(nfc_cmd_en ? 0 : (nfc_addr_en ? 1 : 2), nfc_if_cmd, nfc_dat_dir, nfc_dat_cnt, 1'b0);
      e.acnt = nfc_addr_cnt; e.col = nfc_col_addr; e.row = nfc_row_addr; e.cyc = cyc;
      evq.push_back(e);
    end
    if (op_done) begin
      n_opdone++;
      opdone_cyc = cyc;
      busy_at_done = op_busy;
    end
  end

  initial begin
    int k, d;
    bit rd, abort;
    nfif_cmd_done = 0; nfif_addr_done = 0; nfif_dat_done = 0;
    nfif_data_wr = 0; nfif_data_out = 0; nf_rb = 1;
    forever begin
      @(negedge clk);
      if (!rst && (nfc_cmd_en || nfc_addr_en || nfc_dat_en)) begin
        k  = nfc_cmd_en ? 0 : (nfc_addr_en ? 1 : 2);
        rd = nfc_dat_en && !nfc_dat_dir;
        if (nfc_cmd_en) last_cmd = nfc_if_cmd;
        d = (k == 2) ? $urandom_range(2, 5) : $urandom_range(1, 4);
        abort = 0;
        for (int unsigned i = 1; i <= d; i++) begin
          @(negedge clk);
          nfif_data_wr = 1'b0;
          if (rst) begin abort = 1; break; end
          if (i < d && rd) begin
            nfif_data_wr  = 1'b1;
            nfif_data_out = (last_cmd == 8'h70) ? status_byte : 8'($urandom);
          end
        end
        if (!abort) begin
          case (k)
            0:       nfif_cmd_done  = 1'b1;
            1:       nfif_addr_done = 1'b1;
            default: nfif_dat_done  = 1'b1;
          endcase
          done_cyc.push_back(cyc);
          if (k == 0 && is_confirm(last_cmd)) conf_done_cyc = cyc;
          @(negedge clk);
          nfif_cmd_done = 0; nfif_addr_done = 0; nfif_dat_done = 0;
          if (k == 0 && is_confirm(last_cmd)) begin
            nf_rb = 1'b0;
            for (int j = 0; j < rb_busy && !rb_release && !rst; j++) @(negedge clk);
            nf_rb = 1'b1;
            rb_rise_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] t, input logic [31:0] col, input logic [31:0] row,
                        input logic [5:0] ac, input logic [13:0] dc, input logic [7:0] st,
                        input int busy, input bit stuck, input bit poke);
    ev_t exp[$];
    logic [7:0] c1, c2;
    logic [5:0] exp_ac;
    bit sread, exp_err, ok;
    int start_cyc, w, lo, hi, a, b;
    c1 = (t == 2'b00) ? 8'h00 : (t == 2'b01) ? 8'h80 : (t == 2'b10) ? 8'h60 : 8'hFF;
    c2 = (t == 2'b00) ? 8'h30 : (t == 2'b01) ? 8'h10 : 8'hD0;
    exp.push_back(mk(0, c1, 0, 0, 0));
    if (t != 2'b11) exp.push_back(mk(1, 0, 0, 0, 0));
    if (t == 2'b01) exp.push_back(mk(2, 0, 1, dc, 0));
    if (t != 2'b11) exp.push_back(mk(0, c2, 0, 0, 0));
    sread = !stuck && (t == 2'b01 || t == 2'b10);
    if (!stuck && t == 2'b00) exp.push_back(mk(2, 0, 0, dc, 1));
    if (sread) begin
      exp.push_back(mk(0, 8'h70, 0, 0, 1));
      exp.push_back(mk(2, 0, 0, 14'd1, 0));
      model_status = st;
    end
    exp_err = stuck || (sread && st[0]);
    exp_ac  = (t == 2'b10) ? {ac[5:3], 3'b000} : ac;

    evq.delete(); done_cyc.delete(); n_opdone = 0; n_multi_en = 0;
    status_byte = st;
    rb_busy = stuck ? (1 << 30) : busy;
    @(negedge clk);
    op_type = t; op_col_addr = col; op_row_addr = row; op_addr_cnt = ac; op_dat_cnt = dc;
    op_start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    op_start = 1'b0;
    n_checks++;
    if (op_busy !== 1'b1) begin n_fail++; $error("FAIL busy_after_start obs=%0h exp=1", op_busy); end
    n_checks++;
    if (op_err !== 1'b0) begin n_fail++; $error("FAIL err_clear_on_start obs=%0h exp=0", op_err); end
    if (poke) begin
      repeat (3) @(negedge clk);
      op_type = ~t; op_col_addr = ~col; op_row_addr = ~row; op_addr_cnt = ~ac; op_dat_cnt = ~dc;
      op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
    end
    w = 0;
    while (n_opdone == 0 && w < 4000) begin @(posedge clk); w++; end
    @(negedge clk);
    n_checks++;
    if (n_opdone !== 1) begin n_fail++; $error("FAIL op_done_seen obs=%0d exp=1", n_opdone); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_opdone !== 1) begin n_fail++; $error("FAIL op_done_once obs=%0d exp=1", n_opdone); end
    n_checks++;
    if (busy_at_done !== 1'b0) begin n_fail++; $error("FAIL busy_drop_at_done obs=%0h exp=0", busy_at_done); end
    n_checks++;
    if (op_busy !== 1'b0) begin n_fail++; $error("FAIL busy_after_done obs=%0h exp=0", op_busy); end
    n_checks++;
    if (op_err !== exp_err) begin n_fail++; $error("FAIL op_err obs=%0h exp=%0h", op_err, exp_err); end
    n_checks++;
    if (op_status !== model_status) begin n_fail++; $error("FAIL op_status obs=%0h exp=%0h", op_status, model_status); end
    n_checks++;
    if (n_multi_en !== 0) begin n_fail++; $error("FAIL single_enable obs=%0d exp=0", n_multi_en); end
    n_checks++;
    if (evq.size() !== exp.size()) begin n_fail++; $error("FAIL step_count obs=%0d exp=%0d", evq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < evq.size(); i++) begin
      n_checks++;
      if (evq[i].kind !== exp[i].kind) begin n_fail++; $error("FAIL step_kind obs=%0d exp=%0d", evq[i].kind, exp[i].kind); end
      case (exp[i].kind)
        0: begin
          n_checks++;
          if (evq[i].cmd !== exp[i].cmd) begin n_fail++; $error("FAIL cmd_byte obs=%0h exp=%0h", evq[i].cmd, exp[i].cmd); end
        end
        1: begin
          n_checks++;
          if (evq[i].acnt !== exp_ac) begin n_fail++; $error("FAIL addr_cnt obs=%0h exp=%0h", evq[i].acnt, exp_ac); end
          n_checks++;
          if (evq[i].col !== col) begin n_fail++; $error("FAIL col_addr obs=%0h exp=%0h", evq[i].col, col); end
          n_checks++;
          if (evq[i].row !== row) begin n_fail++; $error("FAIL row_addr obs=%0h exp=%0h", evq[i].row, row); end
        end
        default: begin
          n_checks++;
          if (evq[i].dir !== exp[i].dir) begin n_fail++; $error("FAIL dat_dir obs=%0h exp=%0h", evq[i].dir, exp[i].dir); end
          n_checks++;
          if (evq[i].cnt !== exp[i].cnt) begin n_fail++; $error("FAIL dat_cnt obs=%0h exp=%0h", evq[i].cnt, exp[i].cnt); end
        end
      endcase
      if (i == 0) begin
        n_checks++;
        if (evq[i].cyc !== start_cyc + 1) begin
          n_fail++; $error("FAIL first_enable_latency obs=%0d exp=%0d", evq[i].cyc, start_cyc + 1);
        end
      end else if (i - 1 < done_cyc.size()) begin
        if (!exp[i].arb) begin
          n_checks++;
          if (evq[i].cyc !== done_cyc[i-1] + 2) begin
            n_fail++; $error("FAIL step_spacing obs=%0d exp=%0d", evq[i].cyc, done_cyc[i-1] + 2);
          end
        end else begin
          a  = done_cyc[i-1] + TWB_CYC + 1;
          b  = rb_rise_cyc + 2;
          lo = (a > b) ? a : b;
          a  = done_cyc[i-1] + TWB_CYC + 2;
          b  = rb_rise_cyc + 3;
          hi = ((a > b) ? a : b) + 1;
          ok = (evq[i].cyc >= lo) && (evq[i].cyc <= hi);
          n_checks++;
          if (ok !== 1'b1) begin n_fail++; $error("FAIL rb_wait_exit obs=%0d exp=%0d..%0d", evq[i].cyc, lo, hi); end
        end
      end
    end
    if (stuck) begin
      lo = conf_done_cyc + TWB_CYC + (1 << TO_W) - 1;
      hi = conf_done_cyc + TWB_CYC + (1 << TO_W) + 3;
      ok = (opdone_cyc >= lo) && (opdone_cyc <= hi);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $error("FAIL timeout_latency obs=%0d exp=%0d..%0d", opdone_cyc, lo, hi); end
      rb_release = 1'b1;
      repeat (3) @(negedge clk);
      rb_release = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    n_fail++;
    $error("FAIL watchdog obs=%0d exp=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b1; op_start = 1'b0; op_type = '0; op_col_addr = '0; op_row_addr = '0;
    op_addr_cnt = '0; op_dat_cnt = '0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (w_all !== '0) begin n_fail++; $error("FAIL reset_outputs obs=%0h exp=0", w_all); end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op(2'b00, 32'h0000_0123, 32'h0001_ABCD, 6'b010_010, 14'd2048, 8'h00, 40, 0, 0);
    run_op(2'b01, 32'h0000_0040, 32'h0002_0000, 6'b010_010, 14'd2048, 8'h01, 500, 0, 0);
    run_op(2'b10, 32'hDEAD_BEEF, 32'h0003_0040, 6'b000_010, 14'd100, 8'hE0, 25, 0, 0);
    run_op(2'b11, 32'h0, 32'h0, 6'b000_000, 14'd0, 8'h00, 0, 1, 0);
    run_op(2'b01, 32'h0000_0777, 32'h0000_1234, 6'b001_011, 14'd16, 8'h00, 10, 0, 1);

    evq.delete(); n_opdone = 0;
    @(negedge clk);
    op_type = 2'b01; op_col_addr = 32'h55; op_row_addr = 32'h66; op_addr_cnt = 6'b010_010;
    op_dat_cnt = 14'd8; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    w = 0;
    while (evq.size() < 2 && w < 200) begin @(posedge clk); w++; end
    n_checks++;
    if (evq.size() !== 2) begin n_fail++; $error("FAIL reached_addr_step obs=%0d exp=2", evq.size()); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (w_all !== '0) begin n_fail++; $error("FAIL rst_mid_op_outputs obs=%0h exp=0", w_all); end
    model_status = 8'h00;
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_opdone !== 0) begin n_fail++; $error("FAIL no_done_after_rst obs=%0d exp=0", n_opdone); end

    for (int unsigned n = 0; n < 12; n++) begin
      run_op(2'($urandom), $urandom, $urandom, 6'($urandom), 14'($urandom_range(1, 8191)),
             8'($urandom), $urandom_range(0, 60), 0, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
